// File: rtl/bf_pkg.sv
// Shared constants for the Brainfuck program memory: opcodes, loader error codes
// and the loader state encoding.
package bf_pkg;

    // 4-bit opcodes stored in program memory and decoded by the control FSM
    localparam logic [3:0] OP_LT    = 4'h0;
    localparam logic [3:0] OP_GT    = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_OPEN  = 4'h4;
    localparam logic [3:0] OP_CLOSE = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_STOP  = 4'hF;

    // Loader abort reasons
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CLOSE = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_OPEN  = 2'd3;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ACCEPT,
        LD_WRITE_STOP,
        LD_DONE,
        LD_ERR
    } ld_state_e;

endpackage

// File: rtl/bf_char_encoder.sv
// Maps an ASCII source byte to a program opcode; any non-command byte is a comment.
module bf_char_encoder
    import bf_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_cmd_o,
    output logic [3:0] opcode_o
);

    // Table lookup of the eight command characters
    always_comb begin
        is_cmd_o = 1'b1;
        opcode_o = OP_STOP;
        case (char_i)
            8'h3C:   opcode_o = OP_LT;    // '<'
            8'h3E:   opcode_o = OP_GT;    // '>'
            8'h2B:   opcode_o = OP_INC;   // '+'
            8'h2D:   opcode_o = OP_DEC;   // '-'
            8'h5B:   opcode_o = OP_OPEN;  // '['
            8'h5D:   opcode_o = OP_CLOSE; // ']'
            8'h2E:   opcode_o = OP_OUT;   // '.'
            8'h2C:   opcode_o = OP_IN;    // ','
            default: is_cmd_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_program_loader.sv
// Writer side of the Brainfuck program memory: filters and encodes an ASCII
// source stream, checks bracket balance and appends the stop opcode.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              eof,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [3:0]        prog_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [ADDR_W:0]   prog_len
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        code_q, code_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        wdata_q, wdata_d;

    logic              is_cmd;
    logic [3:0]        opcode;
    logic              char_err;
    logic [ADDR_W:0]   depth_upd;

    bf_char_encoder u_enc (
        .char_i   (char_in),
        .is_cmd_o (is_cmd),
        .opcode_o (opcode)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LD_IDLE;
        else       state_q <= state_d;
    end

    // Counters and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            depth_q <= '0;
            len_q   <= '0;
            code_q  <= ERR_NONE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            depth_q <= depth_d;
            len_q   <= len_d;
            code_q  <= code_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state and datapath: the accepted character is resolved first, then
    // eof is judged against the depth that character leaves behind.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        depth_d   = depth_q;
        len_d     = len_q;
        code_d    = code_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        char_err  = 1'b0;
        depth_upd = depth_q;
        if (start) begin
            state_d = LD_ACCEPT;
            addr_d  = '0;
            depth_d = '0;
            len_d   = '0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                LD_ACCEPT: begin
                    if (char_valid && is_cmd) begin
                        if (opcode == OP_CLOSE && depth_q == '0) begin
                            state_d  = LD_ERR;
                            code_d   = ERR_CLOSE;
                            char_err = 1'b1;
                        end else if (addr_q == LAST_ADDR) begin
                            state_d  = LD_ERR;
                            code_d   = ERR_OVF;
                            char_err = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = opcode;
                            addr_d  = addr_q + ADDR_ONE;
                            len_d   = len_q + CNT_ONE;
                            if (opcode == OP_OPEN)
                                depth_upd = depth_q + CNT_ONE;
                            else if (opcode == OP_CLOSE)
                                depth_upd = depth_q - CNT_ONE;
                        end
                    end
                    depth_d = depth_upd;
                    if (eof && !char_err) begin
                        if (depth_upd != '0) begin
                            state_d = LD_ERR;
                            code_d  = ERR_OPEN;
                        end else begin
                            state_d = LD_WRITE_STOP;
                        end
                    end
                end
                LD_WRITE_STOP: begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = OP_STOP;
                    state_d = LD_DONE;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        char_ready = (state_q == LD_ACCEPT);
        busy       = (state_q == LD_ACCEPT) || (state_q == LD_WRITE_STOP);
        done       = (state_q == LD_DONE);
        error      = (state_q == LD_ERR);
    end

    assign prog_we    = we_q;
    assign prog_addr  = waddr_q;
    assign prog_data  = wdata_q;
    assign error_code = code_q;
    assign prog_len   = len_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Bench for bf_program_loader: a full-size and a tiny (ADDR_W=3) instance share
// one stimulus stream; each is compared against a string-level load model.
module tb_bf_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] char_in;
    logic       char_valid;
    logic       eof;

    logic       b_ready, b_we, b_busy, b_done, b_error;
    logic [7:0] b_addr;
    logic [3:0] b_data;
    logic [1:0] b_code;
    logic [8:0] b_len;

    logic       s_ready, s_we, s_busy, s_done, s_error;
    logic [2:0] s_addr;
    logic [3:0] s_data;
    logic [1:0] s_code;
    logic [3:0] s_len;

    int n_cmp = 0;
    int n_bad = 0;

    int obs_b[$];
    int obs_s[$];

    int exp_q[$];
    int exp_st;
    int exp_code;
    int exp_len;

    always #5 clk = ~clk;

    bf_program_loader #(.ADDR_W(8)) u_big (
        .clk(clk), .reset(reset), .start(start), .char_in(char_in),
        .char_valid(char_valid), .char_ready(b_ready), .eof(eof),
        .prog_we(b_we), .prog_addr(b_addr), .prog_data(b_data),
        .busy(b_busy), .done(b_done), .error(b_error),
        .error_code(b_code), .prog_len(b_len)
    );

    bf_program_loader #(.ADDR_W(3)) u_small (
        .clk(clk), .reset(reset), .start(start), .char_in(char_in),
        .char_valid(char_valid), .char_ready(s_ready), .eof(eof),
        .prog_we(s_we), .prog_addr(s_addr), .prog_data(s_data),
        .busy(s_busy), .done(s_done), .error(s_error),
        .error_code(s_code), .prog_len(s_len)
    );

    // Collect every write pulse as addr*16+data
    always @(negedge clk) begin
        if (b_we) obs_b.push_back(int'(b_addr) * 16 + int'(b_data));
        if (s_we) obs_s.push_back(int'(s_addr) * 16 + int'(s_data));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int enc(input byte c);
        string cmds = "<>+-[].,";
        for (int k = 0; k < cmds.len(); k++)
            if (cmds[k] == c) return k;
        return -1;
    endfunction

    // Reference load: st 0 = still accepting, 1 = done, 2 = error
    task automatic model(input byte s[$], input bit has_eof, input int cap);
        int depth = 0;
        int addr  = 0;
        int op;
        exp_q.delete();
        exp_st   = 0;
        exp_code = 0;
        exp_len  = 0;
        foreach (s[i]) begin
            op = enc(s[i]);
            if (op < 0) continue;
            if (op == 5 && depth == 0) begin
                exp_st = 2; exp_code = 1; exp_len = addr; return;
            end
            if (addr == cap - 1) begin
                exp_st = 2; exp_code = 2; exp_len = addr; return;
            end
            exp_q.push_back(addr * 16 + op);
            addr++;
            if (op == 4) depth++;
            if (op == 5) depth--;
        end
        exp_len = addr;
        if (has_eof) begin
            if (depth != 0) begin
                exp_st = 2; exp_code = 3;
            end else begin
                exp_q.push_back(addr * 16 + 15);
                exp_st = 1;
            end
        end
    endtask

    task automatic check_dut(input string tag, input int which);
        logic       rdy, bsy, dn, er;
        logic [1:0] code;
        int         len;
        int         obs[$];
        if (which == 0) begin
            rdy = b_ready; bsy = b_busy; dn = b_done; er = b_error;
            code = b_code; len = int'(b_len); obs = obs_b;
        end else begin
            rdy = s_ready; bsy = s_busy; dn = s_done; er = s_error;
            code = s_code; len = int'(s_len); obs = obs_s;
        end
        chk({tag, ".done"},       32'(dn),   32'(exp_st == 1));
        chk({tag, ".error"},      32'(er),   32'(exp_st == 2));
        chk({tag, ".error_code"}, 32'(code), 32'(exp_code));
        chk({tag, ".busy"},       32'(bsy),  32'(exp_st == 0));
        chk({tag, ".char_ready"}, 32'(rdy),  32'(exp_st == 0));
        chk({tag, ".prog_len"},   32'(len),  32'(exp_len));
        chk({tag, ".n_writes"},   32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk($sformatf("%s.write%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".b_ready"}, 32'(b_ready), 0);
        chk({tag, ".b_we"},    32'(b_we),    0);
        chk({tag, ".b_addr"},  32'(b_addr),  0);
        chk({tag, ".b_data"},  32'(b_data),  0);
        chk({tag, ".b_busy"},  32'(b_busy),  0);
        chk({tag, ".b_done"},  32'(b_done),  0);
        chk({tag, ".b_error"}, 32'(b_error), 0);
        chk({tag, ".b_code"},  32'(b_code),  0);
        chk({tag, ".b_len"},   32'(b_len),   0);
        chk({tag, ".s_we"},    32'(s_we),    0);
        chk({tag, ".s_busy"},  32'(s_busy),  0);
        chk({tag, ".s_len"},   32'(s_len),   0);
    endtask

    // mode: 0 no eof, 1 eof on a separate cycle, 2 eof alongside the last char
    task automatic run_load(input string tag, input string src, input int mode, input bit gaps);
        byte q[$];
        for (int i = 0; i < src.len(); i++) q.push_back(src[i]);
        @(negedge clk);
        obs_b.delete();
        obs_s.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                char_valid = 1'b0;
                eof        = 1'b0;
                @(negedge clk);
            end
            if (!b_ready) break;
            char_in    = q[i];
            char_valid = 1'b1;
            eof        = (mode == 2) && (i == q.size() - 1);
            @(negedge clk);
        end
        char_valid = 1'b0;
        eof        = 1'b0;
        if (mode == 1 && b_ready) begin
            eof = 1'b1;
            @(negedge clk);
            eof = 1'b0;
        end
        repeat (4) @(negedge clk);
        model(q, mode != 0, 256);
        check_dut({tag, ".big"}, 0);
        model(q, mode != 0, 8);
        check_dut({tag, ".small"}, 1);
    endtask

    initial begin
        string alpha = "+-<>[].,[]ab \n";
        string s;
        byte   c;
        reset      = 1'b1;
        start      = 1'b0;
        char_in    = '0;
        char_valid = 1'b0;
        eof        = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        run_load("t1", "+[->+<].", 1, 1'b0);
        run_load("t2", "a+ b\n-", 1, 1'b0);
        run_load("t3", "]", 1, 1'b0);
        run_load("t4", "[[]", 1, 1'b0);
        run_load("t5", "+++++++", 1, 1'b0);
        run_load("t6", "++++++++", 0, 1'b0);
        run_load("t7b", "[]", 2, 1'b0);
        run_load("t7c", "[", 2, 1'b0);
        run_load("t7d", "+]", 2, 1'b0);

        // Reset mid-stream must clear outputs before any clock edge
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c          = 8'h2B;
            char_in    = c;
            char_valid = 1'b1;
            @(negedge clk);
        end
        char_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        run_load("t7a", ".", 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int len;
            s   = "";
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                c = alpha[$urandom_range(0, alpha.len() - 1)];
                s = {s, string'(c)};
            end
            run_load($sformatf("rnd%0d", n), s, $urandom_range(0, 2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
